if_fetch_buffer: RTL and testbench

//  Instruction-fetch stage between the PC register and the IF/ID boundary. Takes the fetch

---
 rtl/if_fetch_buffer.sv | 125 ++++++++++++
 tb/tb_if_fetch_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: single-outstanding req/ack read on instruction memory feeding a
// show-ahead {pc, instr} FIFO drained by ID with valid/ready; flush discards queued and in-flight fetches.
module if_fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      pc_i,
    output logic             pc_adv_o,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_data_i,
    input  logic             flush_i,
    output logic             id_valid_o,
    input  logic             id_ready_i,
    output logic [31:0]      id_instr_o,
    output logic [31:0]      id_pc_o,
    output logic [PTR_W:0]   count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } state_t;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic              req_d;
    logic [31:0]       addr_d;
    logic              issue, push, pop;

    logic [31:0]       pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]    count_q;

    // Full check uses the count before this cycle's pop, so push can never hit a full FIFO.
    assign issue    = start_i & ~flush_i & (count_q < DEPTH_C);
    assign push     = (state_q == REQ) & imem_ack_i & ~flush_i;
    assign pop      = id_valid_o & id_ready_i & ~flush_i;
    assign pc_adv_o = push;

    always_comb begin
        // NOTE: every variable gets its default before the case so no path infers a latch.
        state_d = state_q;
        req_d   = imem_req_o;
        addr_d  = imem_addr_o;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_i;
                end
            end
            REQ: begin
                if (imem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else if (flush_i) begin
                    state_d = KILL;
                end
            end
            KILL: begin
                // Memory must still complete the abandoned read; its data is discarded.
                if (imem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            imem_req_o  <= 1'b0;
            imem_addr_o <= '0;
        end else begin
            state_q     <= state_d;
            imem_req_o  <= req_d;
            imem_addr_o <= addr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= imem_addr_o;
            instr_mem[wr_ptr_q] <= imem_data_i;
        end
    end

    assign id_valid_o = (count_q != '0);
    assign id_pc_o    = id_valid_o ? pc_mem[rd_ptr_q]    : 32'h0;
    assign id_instr_o = id_valid_o ? instr_mem[rd_ptr_q] : 32'h0;
    assign count_o    = count_q;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer: per-cycle vectors of {inputs, expected outputs},
// inputs driven on the falling edge and outputs compared shortly after.
module tb_if_fetch_buffer;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] ND   = 32'hFFFF_FFFF;
    localparam logic [31:0] I00  = 32'h8C01_0004;
    localparam logic [31:0] I04  = 32'h1111_0004;
    localparam logic [31:0] I08  = 32'h2222_0008;
    localparam logic [31:0] I0C  = 32'h3333_000C;
    localparam logic [31:0] I40  = 32'h4444_0040;
    localparam logic [31:0] I20  = 32'h5555_0020;
    localparam logic [31:0] I24  = 32'h6666_0024;
    localparam logic [31:0] I28  = 32'h7777_0028;
    localparam logic [31:0] I2C  = 32'h8888_002C;
    localparam logic [31:0] I30  = 32'h9999_0030;

    typedef struct {
        logic        rst;
        logic        start;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] data;
        logic        flush;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_adv;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [2:0]  e_cnt;
    } vec_t;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic        pc_adv_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        flush_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [2:0]  count_o;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];

    if_fetch_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .pc_i        (pc_i),
        .pc_adv_o    (pc_adv_o),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .flush_i     (flush_i),
        .id_valid_o  (id_valid_o),
        .id_ready_i  (id_ready_i),
        .id_instr_o  (id_instr_o),
        .id_pc_o     (id_pc_o),
        .count_o     (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic vec_t mk(input logic rst, input logic start, input logic [31:0] pc,
                                input logic ack, input logic [31:0] data, input logic flush,
                                input logic ready, input logic e_req, input logic [31:0] e_addr,
                                input logic e_adv, input logic e_valid, input logic [31:0] e_pc,
                                input logic [31:0] e_instr, input logic [2:0] e_cnt);
        vec_t v;
        v.rst = rst;       v.start = start;     v.pc = pc;
        v.ack = ack;       v.data = data;       v.flush = flush;
        v.ready = ready;   v.e_req = e_req;     v.e_addr = e_addr;
        v.e_adv = e_adv;   v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        rst_i       = v.rst;
        start_i     = v.start;
        pc_i        = v.pc;
        imem_ack_i  = v.ack;
        imem_data_i = v.data;
        flush_i     = v.flush;
        id_ready_i  = v.ready;
        #2;
        check({tag, " req"},   {31'b0, imem_req_o}, {31'b0, v.e_req});
        check({tag, " addr"},  imem_addr_o,         v.e_addr);
        check({tag, " adv"},   {31'b0, pc_adv_o},   {31'b0, v.e_adv});
        check({tag, " valid"}, {31'b0, id_valid_o}, {31'b0, v.e_valid});
        check({tag, " id_pc"}, id_pc_o,             v.e_pc);
        check({tag, " instr"}, id_instr_o,          v.e_instr);
        check({tag, " count"}, {29'b0, count_o},    {29'b0, v.e_cnt});
        @(negedge clk_i);
    endtask

    initial begin
        // First reset edge happens before any output is defined, so it is not compared.
        rst_i = 1'b1; start_i = 1'b1; pc_i = 32'h0; imem_ack_i = 1'b1;
        imem_data_i = ND; flush_i = 1'b0; id_ready_i = 1'b0;
        @(negedge clk_i);

        //               rst start pc        ack data        fl ready  req addr      adv val pc        instr  cnt
        // Second reset cycle with start and ack high: everything idle.
        tbl.push_back(mk(H, H, 32'h00, H, ND,           L, L,   L, 32'h00, L, L, 32'h00, 32'h0, 3'd0));
        // Fetch 0x0 with one-cycle ack, then fill the FIFO with 0x4, 0x8, 0xC while ID stalls.
        tbl.push_back(mk(L, H, 32'h00, L, ND,           L, L,   L, 32'h00, L, L, 32'h00, 32'h0, 3'd0));
        tbl.push_back(mk(L, H, 32'h00, H, I00,          L, L,   H, 32'h00, H, L, 32'h00, 32'h0, 3'd0));
        tbl.push_back(mk(L, H, 32'h04, L, ND,           L, L,   L, 32'h00, L, H, 32'h00, I00,   3'd1));
        tbl.push_back(mk(L, H, 32'h04, H, I04,          L, L,   H, 32'h04, H, H, 32'h00, I00,   3'd1));
        tbl.push_back(mk(L, H, 32'h08, L, ND,           L, L,   L, 32'h04, L, H, 32'h00, I00,   3'd2));
        tbl.push_back(mk(L, H, 32'h08, H, I08,          L, L,   H, 32'h08, H, H, 32'h00, I00,   3'd2));
        tbl.push_back(mk(L, H, 32'h0C, L, ND,           L, L,   L, 32'h08, L, H, 32'h00, I00,   3'd3));
        tbl.push_back(mk(L, H, 32'h0C, H, I0C,          L, L,   H, 32'h0C, H, H, 32'h00, I00,   3'd3));
        // Full: no new request while start_i stays high.
        tbl.push_back(mk(L, H, 32'h10, L, ND,           L, L,   L, 32'h0C, L, H, 32'h00, I00,   3'd4));
        tbl.push_back(mk(L, H, 32'h10, L, ND,           L, L,   L, 32'h0C, L, H, 32'h00, I00,   3'd4));
        // One pop; issue sees the pre-pop count, so the request for 0x10 comes a cycle later.
        tbl.push_back(mk(L, H, 32'h10, L, ND,           L, H,   L, 32'h0C, L, H, 32'h00, I00,   3'd4));
        tbl.push_back(mk(L, H, 32'h10, L, ND,           L, L,   L, 32'h0C, L, H, 32'h04, I04,   3'd3));
        // Flush while 0x10 is in flight: KILL, FIFO emptied, late ack dropped, refetch at 0x40.
        tbl.push_back(mk(L, H, 32'h10, L, ND,           H, L,   H, 32'h10, L, H, 32'h04, I04,   3'd3));
        tbl.push_back(mk(L, H, 32'h40, L, ND,           L, L,   H, 32'h10, L, L, 32'h00, 32'h0, 3'd0));
        tbl.push_back(mk(L, H, 32'h40, H, 32'hDEADBEEF, L, L,   H, 32'h10, L, L, 32'h00, 32'h0, 3'd0));
        tbl.push_back(mk(L, H, 32'h40, L, ND,           L, L,   L, 32'h10, L, L, 32'h00, 32'h0, 3'd0));
        tbl.push_back(mk(L, H, 32'h40, H, I40,          L, L,   H, 32'h40, H, L, 32'h00, 32'h0, 3'd0));
        tbl.push_back(mk(L, L, 32'h44, L, ND,           L, L,   L, 32'h40, L, H, 32'h40, I40,   3'd1));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Issue 0x20 while popping 0x40, then ack five cycles late with start_i dropped.
        apply(mk(L, H, 32'h20, L, ND,  L, H,  L, 32'h40, L, H, 32'h40, I40, 3'd1), "slow_issue");
        for (int i = 0; i < 5; i++)
            apply(mk(L, L, 32'h99, L, ND, L, L,  H, 32'h20, L, L, 32'h00, 32'h0, 3'd0),
                  $sformatf("slow_wait%0d", i));
        apply(mk(L, L, 32'h99, H, I20, L, L,  H, 32'h20, H, L, 32'h00, 32'h0, 3'd0), "slow_ack");
        apply(mk(L, L, 32'h99, L, ND,  L, L,  L, 32'h20, L, H, 32'h20, I20, 3'd1), "slow_push");

        // Build count 2, then ack and pop together: count holds, order kept.
        apply(mk(L, H, 32'h24, L, ND,  L, L,  L, 32'h20, L, H, 32'h20, I20, 3'd1), "pp_issue1");
        apply(mk(L, L, 32'h24, H, I24, L, L,  H, 32'h24, H, H, 32'h20, I20, 3'd1), "pp_ack1");
        apply(mk(L, H, 32'h28, L, ND,  L, L,  L, 32'h24, L, H, 32'h20, I20, 3'd2), "pp_issue2");
        apply(mk(L, L, 32'h28, H, I28, L, H,  H, 32'h28, H, H, 32'h20, I20, 3'd2), "pp_ackpop");
        apply(mk(L, L, 32'h28, L, ND,  L, H,  L, 32'h28, L, H, 32'h24, I24, 3'd2), "pp_pop");
        apply(mk(L, L, 32'h28, L, ND,  L, L,  L, 32'h28, L, H, 32'h28, I28, 3'd1), "pp_head");

        // Back to count 2 across the pointer wrap, then ack+pop+flush together, flush held.
        apply(mk(L, H, 32'h2C, L, ND,  L, L,  L, 32'h28, L, H, 32'h28, I28, 3'd1), "fl_issue1");
        apply(mk(L, L, 32'h2C, H, I2C, L, L,  H, 32'h2C, H, H, 32'h28, I28, 3'd1), "fl_ack1");
        apply(mk(L, H, 32'h30, L, ND,  L, L,  L, 32'h2C, L, H, 32'h28, I28, 3'd2), "fl_issue2");
        apply(mk(L, L, 32'h30, H, I30, H, H,  H, 32'h30, L, H, 32'h28, I28, 3'd2), "fl_ackpop");
        apply(mk(L, H, 32'h34, L, ND,  H, L,  L, 32'h30, L, L, 32'h00, 32'h0, 3'd0), "fl_held");
        apply(mk(L, L, 32'h34, L, ND,  L, L,  L, 32'h30, L, L, 32'h00, 32'h0, 3'd0), "fl_after");

        // Reset in the middle of a request abandons it; a stray ack in IDLE is ignored.
        apply(mk(L, H, 32'h50, L, ND,  L, L,  L, 32'h30, L, L, 32'h00, 32'h0, 3'd0), "rst_issue");
        apply(mk(H, H, 32'h50, L, ND,  L, L,  H, 32'h50, L, L, 32'h00, 32'h0, 3'd0), "rst_mid");
        apply(mk(L, L, 32'h50, H, ND,  L, L,  L, 32'h00, L, L, 32'h00, 32'h0, 3'd0), "rst_stray");
        apply(mk(L, L, 32'h50, L, ND,  L, L,  L, 32'h00, L, L, 32'h00, 32'h0, 3'd0), "rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
